// File: rtl/mips_cpu_multdiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the MIPS HI/LO pair.
// Shift-add multiply and restoring divide, one bit per cycle, with a final sign-fix cycle.
module mips_cpu_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0]   opnd_p1;
  logic               is_div_p1, neg_q_p1, neg_r_p1, dz_p1;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     msum, rsh, rdiff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               sgn_op;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && $signed(v) < 0) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign sgn_op = ~op[0];
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration step: multiply keeps {product_hi, multiplier}, divide keeps {remainder, dividend/quotient}
  always_comb begin
    msum  = {1'b0, acc_p1[2*WIDTH-1:WIDTH]} + (acc_p1[0] ? {1'b0, opnd_p1} : '0);
    rsh   = {acc_p1[2*WIDTH-1:WIDTH], acc_p1[WIDTH-1]};
    rdiff = rsh - {1'b0, opnd_p1};
    if (is_div_p1) begin
      if (rdiff[WIDTH]) acc_nxt = {rsh[WIDTH-1:0], acc_p1[WIDTH-2:0], 1'b0};
      else              acc_nxt = {rdiff[WIDTH-1:0], acc_p1[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {msum, acc_p1[WIDTH-1:1]};
    end
    prod_fix = apply_sign2(acc_p1, neg_q_p1);
    q_fix    = apply_sign(acc_p1[WIDTH-1:0], neg_q_p1);
    r_fix    = apply_sign(acc_p1[2*WIDTH-1:WIDTH], neg_r_p1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: cnt <= cnt + CW'(1);
        FIX: begin
          done <= 1'b1;
          if (is_div_p1) begin
            hi <= r_fix;
            lo <= dz_p1 ? '1 : q_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture on start, then one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div_p1 <= op[1];
      neg_q_p1  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_p1  <= sgn_op & a[WIDTH-1];
      dz_p1     <= (b == '0);
      opnd_p1   <= op[1] ? mag(b, sgn_op) : mag(a, sgn_op);
      acc_p1    <= {{WIDTH{1'b0}}, (op[1] ? mag(a, sgn_op) : mag(b, sgn_op))};
    end else if (state == RUN) begin
      acc_p1 <= acc_nxt;
    end
  end

endmodule

// File: doc/mips_cpu_multdiv.md
# mips_cpu_multdiv

Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS CPU. It sits directly downstream of the instruction decoder. For R-type MULT, MULTU, DIV, DIVU, MTHI and MTLO (decoder Aluop = 0, funct-qualified), it takes rs/rt operands and produces HI/LO for MFHI/MFLO. Each operation takes a fixed number of cycles; the datapath stalls on `busy`.

## Interface

Parameters:
- `WIDTH`, default 32: operand and HI/LO width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request an operation; sampled only in IDLE.
- `op`  in  2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH: rs operand (multiplicand or dividend).
- `b`  in  WIDTH: rt operand (multiplier or divisor).
- `mthi`  in  1: write `wdata` into HI.
- `mtlo`  in  1: write `wdata` into LO.
- `wdata`  in  WIDTH: rs value for MTHI/MTLO.
- `hi`  out  WIDTH: HI register, always readable.
- `lo`  out  WIDTH: LO register, always readable.
- `busy`  out  1: operation in progress; CPU must stall MULT/DIV/MFHI/MFLO/MTHI/MTLO.
- `done`  out  1: one-cycle pulse; HI/LO hold the new result.

## Operation

- States: IDLE, RUN, FIX.
- IDLE:
  - If `start`: latch |a|, |b| (magnitude for signed ops, raw for unsigned), the result sign flags and `op`. Clear accumulator and counter. Go to RUN.
  - Else `mthi`/`mtlo` write HI/LO. Both may be asserted together; both writes occur.
- RUN: one iteration per cycle, counter 0..WIDTH-1. Go to FIX after the iteration with counter = WIDTH-1.
  - Multiply: shift-add, 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per cycle, WIDTH-bit remainder.
- FIX: apply sign correction, write HI/LO, assert `done`, return to IDLE.
  - Multiply: {HI,LO} = product, negated if exactly one operand was negative (MULT only).
  - Divide: LO = quotient, HI = remainder.
    - Quotient is negated iff the operand signs differ.
    - Remainder takes the sign of the dividend.
    - Quotient truncates toward zero.
- Divide by zero (b = 0, DIV or DIVU): no trap, same latency. HI = a (unchanged dividend), LO = all ones.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Wraps; no flag.
- `start` while not IDLE: ignored. `mthi`/`mtlo` while not IDLE: ignored.
- `start` together with `mthi`/`mtlo` in IDLE: start wins; the MT writes are dropped.
- `op`, `a`, `b` need only be valid in the `start` cycle.

## Timing

- Reset: state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, counter = 0.
- Reset asserted during RUN/FIX aborts the operation. No `done` pulse. HI/LO are cleared.
- Let the `start` edge be E0. Then:
  - `busy` is 1 after E0.
  - The RUN iterations occur on edges E1..E32.
  - FIX occurs on edge E33.
  - After E33: `hi`/`lo` show the result, `done` = 1, `busy` = 0.
  - After E34: `done` = 0.
  - Total latency from `start` to result is WIDTH+2 edges.
- A new `start` may be accepted in the same cycle `done` is high (back-to-back, no gap).
- MTHI/MTLO: `hi`/`lo` update after the edge on which they are sampled; latency 1.
- `hi`/`lo` never change during RUN. Intermediate state is held in internal registers only.

## Test plan

- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 edges, `done` pulses one cycle; HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT -3 (0xFFFFFFFD) x 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. Then MULT 0x80000000 x 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 -> LO = 3, HI = 1. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 100 / 0 -> HI = 0x00000064, LO = 0xFFFFFFFF, same 34-edge latency.
- MTHI 0x12345678 and MTLO 0x9ABCDEF0 in the same cycle -> both registers updated next edge.
  - A second `start` issued mid-RUN is ignored; the first result is unchanged.
  - MTLO issued during RUN is ignored.
- Reset asserted at counter = 10 of a MULT -> next cycle `busy` = 0, `done` = 0, HI = LO = 0. A new `start` then completes normally.
